inst_encoder: RTL and testbench

Packs decoded RV32I instruction fields (format, opcode, registers, funct fields, immediate) back into a 32-bit instruction word. It is the inverse of the core's immediate/field extraction: it scatters immediate bits into the I/S/B/U/J layouts and range-checks them. It feeds the instruction-memory loader and test-program builder. Accepted words are tagged with a sequential byte address and buffered in a small FIFO behind a valid/ready handshake.

---
 rtl/riscv_pkg.sv | 52 +++++
 rtl/inst_encoder_if.sv | 38 +++
 rtl/sync_fifo.sv | 59 +++++
 rtl/inst_encoder.sv | 144 ++++++++++++++
 tb/tb_inst_encoder.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding types and constants for the instruction encoder.
package riscv_pkg;

    // Field-bundle format selector; value 7 is reserved and rejected.
    typedef enum logic [2:0] {
        FmtR       = 3'd0,
        FmtI       = 3'd1,
        FmtIShift  = 3'd2,
        FmtS       = 3'd3,
        FmtB       = 3'd4,
        FmtU       = 3'd5,
        FmtJ       = 3'd6,
        FmtIllegal = 3'd7
    } fmt_e;

    // Error codes carried with each buffered entry.
    typedef enum logic [1:0] {
        ErrNone     = 2'd0,
        ErrRange    = 2'd1,
        ErrMisalign = 2'd2,
        ErrIllegal  = 2'd3
    } err_e;

    localparam logic [6:0] OpcOp     = 7'h33;
    localparam logic [6:0] OpcOpImm  = 7'h13;
    localparam logic [6:0] OpcLoad   = 7'h03;
    localparam logic [6:0] OpcStore  = 7'h23;
    localparam logic [6:0] OpcBranch = 7'h63;
    localparam logic [6:0] OpcJal    = 7'h6f;
    localparam logic [6:0] OpcLui    = 7'h37;
    localparam logic [6:0] OpcAuipc  = 7'h17;
    localparam logic [6:0] OpcSystem = 7'h73;

    // addi x0,x0,0 -- substituted for any entry that fails its checks.
    localparam logic [31:0] Nop = 32'h0000_0013;

    // True when v[31:msb] are all equal, i.e. v fits a signed field of msb+1 bits.
    function automatic logic sext_fits(input logic [31:0] v, input int msb);
        logic all_ones;
        logic all_zeros;
        all_ones  = 1'b1;
        all_zeros = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= msb) begin
                all_ones  = all_ones & v[i];
                all_zeros = all_zeros & ~v[i];
            end
        end
        return all_ones | all_zeros;
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Field-bundle input, address-load control and encoded-word output bundle.
interface inst_encoder_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              addr_load;
    logic [ADDR_W-1:0] addr_load_val;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [1:0]        out_err_code;
    logic              err_sticky;

    // Producer/consumer side (program builder, loader).
    modport master (
        output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
        output in_imm, addr_load, addr_load_val, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, out_err, out_err_code, err_sticky
    );

    // Encoder side.
    modport slave (
        input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
        input  in_imm, addr_load, addr_load_val, out_ready,
        output in_ready, out_valid, out_inst, out_addr, out_err, out_err_code, err_sticky
    );
endinterface

// File: rtl/sync_fifo.sv
// Count-based synchronous FIFO; head data reads as zero while empty.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [Width-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_valid,
    output logic [Width-1:0] o_data
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [PtrW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == DepthCnt);
    assign o_valid = (r_count != '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & o_valid;
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

    // Pointer and occupancy tracking; power-of-2 depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage write; contents need no reset because the count masks them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Packs RV32I fields into an instruction word, range-checks the immediate,
// tags it with a byte address and buffers it behind a valid/ready FIFO.
module inst_encoder
    import riscv_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       DEPTH     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_encoder_if.slave bus
);
    localparam int unsigned FifoW = 32 + ADDR_W + 2;

    fmt_e              w_fmt;
    err_e              w_code;
    logic [31:0]       w_raw;
    logic [31:0]       w_inst;
    logic [31:0]       w_imm;
    logic              w_accept;
    logic              w_pop;
    logic              w_full;
    logic              w_head_valid;
    logic [FifoW-1:0]  w_push_data;
    logic [FifoW-1:0]  w_head;
    logic [1:0]        w_head_code;
    logic [ADDR_W-1:0] w_load_addr;
    logic [ADDR_W-1:0] w_entry_addr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err_sticky;

    assign w_fmt = fmt_e'(bus.in_fmt);
    assign w_imm = bus.in_imm;

    // Scatter fields into the selected layout and classify the immediate.
    always_comb begin
        w_raw  = '0;
        w_code = ErrNone;
        case (w_fmt)
            FmtR: begin
                w_raw = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd,
                         bus.in_opcode};
            end
            FmtI: begin
                w_raw = {w_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
                if (!sext_fits(w_imm, 11)) begin
                    w_code = ErrRange;
                end
            end
            FmtIShift: begin
                w_raw = {bus.in_funct7, w_imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd,
                         bus.in_opcode};
                if (|w_imm[31:5]) begin
                    w_code = ErrRange;
                end
            end
            FmtS: begin
                w_raw = {w_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, w_imm[4:0],
                         bus.in_opcode};
                if (!sext_fits(w_imm, 11)) begin
                    w_code = ErrRange;
                end
            end
            FmtB: begin
                w_raw = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                         w_imm[4:1], w_imm[11], bus.in_opcode};
                // Misalignment outranks range; even values fitting 13 bits top out at 4094.
                if (w_imm[0]) begin
                    w_code = ErrMisalign;
                end else if (!sext_fits(w_imm, 12)) begin
                    w_code = ErrRange;
                end
            end
            FmtU: begin
                w_raw = {w_imm[31:12], bus.in_rd, bus.in_opcode};
                if (|w_imm[11:0]) begin
                    w_code = ErrRange;
                end
            end
            FmtJ: begin
                w_raw = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.in_rd,
                         bus.in_opcode};
                if (w_imm[0]) begin
                    w_code = ErrMisalign;
                end else if (!sext_fits(w_imm, 20)) begin
                    w_code = ErrRange;
                end
            end
            default: begin
                w_code = ErrIllegal;
            end
        endcase
    end

    assign w_inst = (w_code == ErrNone) ? w_raw : Nop;

    assign bus.in_ready = rst_n & ~w_full;
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_pop        = w_head_valid & bus.out_ready;

    // Loaded addresses are forced word-aligned; a load on an accept tags that entry.
    assign w_load_addr  = {bus.addr_load_val[ADDR_W-1:2], 2'b00};
    assign w_entry_addr = bus.addr_load ? w_load_addr : r_addr;
    assign w_push_data  = {w_inst, w_entry_addr, w_code};

    // Address counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr       <= BASE_ADDR;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= w_entry_addr + ADDR_W'(4);
                if (w_code != ErrNone) begin
                    r_err_sticky <= 1'b1;
                end
            end else if (bus.addr_load) begin
                r_addr <= w_load_addr;
            end
        end
    end

    sync_fifo #(
        .Width (FifoW),
        .Depth (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_valid (w_head_valid),
        .o_data  (w_head)
    );

    assign {bus.out_inst, bus.out_addr, w_head_code} = w_head;
    assign bus.out_valid    = w_head_valid;
    assign bus.out_err_code = w_head_code;
    assign bus.out_err      = |w_head_code;
    assign bus.err_sticky   = r_err_sticky;

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized and directed bench for inst_encoder with a queue-based reference model.
module tb_inst_encoder;
    import riscv_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h0;
    localparam int          DEPTH  = 2;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [1:0]  code;
    } ent_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    ent_t q[$];
    logic [31:0] m_addr;
    bit   m_sticky;
    bit   last_acc;

    inst_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    inst_encoder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: arithmetic range tests and shift/mask placement.
    function automatic void ref_encode(input logic [2:0] fmt, input logic [6:0] op,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic [31:0] imm,
                                       output logic [31:0] word, output logic [1:0] code);
        longint s;
        s    = longint'($signed(imm));
        code = 2'd0;
        word = 32'h0;
        case (fmt)
            3'd0: word = 32'(op) | 32'(rd) << 7 | 32'(f3) << 12 | 32'(rs1) << 15
                       | 32'(rs2) << 20 | 32'(f7) << 25;
            3'd1: begin
                if (s < -2048 || s > 2047) code = 2'd1;
                word = 32'(op) | 32'(rd) << 7 | 32'(f3) << 12 | 32'(rs1) << 15 | imm << 20;
            end
            3'd2: begin
                if (imm > 32'd31) code = 2'd1;
                word = 32'(op) | 32'(rd) << 7 | 32'(f3) << 12 | 32'(rs1) << 15
                     | (imm & 32'd31) << 20 | 32'(f7) << 25;
            end
            3'd3: begin
                if (s < -2048 || s > 2047) code = 2'd1;
                word = 32'(op) | (imm & 32'd31) << 7 | 32'(f3) << 12 | 32'(rs1) << 15
                     | 32'(rs2) << 20 | ((imm >> 5) & 32'd127) << 25;
            end
            3'd4: begin
                if (imm % 2 != 0) code = 2'd2;
                else if (s < -4096 || s > 4094) code = 2'd1;
                word = 32'(op) | ((imm >> 11) & 32'd1) << 7 | ((imm >> 1) & 32'd15) << 8
                     | 32'(f3) << 12 | 32'(rs1) << 15 | 32'(rs2) << 20
                     | ((imm >> 5) & 32'd63) << 25 | ((imm >> 12) & 32'd1) << 31;
            end
            3'd5: begin
                if (imm % 4096 != 0) code = 2'd1;
                word = 32'(op) | 32'(rd) << 7 | (imm & 32'hFFFF_F000);
            end
            3'd6: begin
                if (imm % 2 != 0) code = 2'd2;
                else if (s < -longint'(1 << 20) || s > longint'((1 << 20) - 2)) code = 2'd1;
                word = 32'(op) | 32'(rd) << 7 | ((imm >> 12) & 32'd255) << 12
                     | ((imm >> 11) & 32'd1) << 20 | ((imm >> 1) & 32'd1023) << 21
                     | ((imm >> 20) & 32'd1) << 31;
            end
            default: code = 2'd3;
        endcase
        if (code != 2'd0) word = Nop;
    endfunction

    // One clock: compare outputs against the model, update the model, advance to negedge.
    task automatic cycle();
        ent_t e;
        bit   acc;
        bit   pop;
        #1;
        check("in_ready", 64'(bus.in_ready), 64'(rst_n && q.size() < DEPTH));
        if (rst_n) begin
            check("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                check("out_inst", 64'(bus.out_inst), 64'(q[0].inst));
                check("out_addr", 64'(bus.out_addr), 64'(q[0].addr));
                check("out_err", 64'(bus.out_err), 64'(q[0].code != 2'd0));
                check("out_err_code", 64'(bus.out_err_code), 64'(q[0].code));
            end
            check("err_sticky", 64'(bus.err_sticky), 64'(m_sticky));
        end
        acc = rst_n && bus.in_valid && q.size() < DEPTH;
        pop = rst_n && q.size() > 0 && bus.out_ready;
        if (!rst_n) begin
            q.delete();
            m_addr   = BASE;
            m_sticky = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                ref_encode(bus.in_fmt, bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2,
                           bus.in_funct3, bus.in_funct7, bus.in_imm, e.inst, e.code);
                e.addr = bus.addr_load ? (bus.addr_load_val & 32'hFFFF_FFFC) : m_addr;
                m_addr = e.addr + 32'd4;
                if (e.code != 2'd0) m_sticky = 1'b1;
                q.push_back(e);
            end else if (bus.addr_load) begin
                m_addr = bus.addr_load_val & 32'hFFFF_FFFC;
            end
        end
        last_acc = acc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm, input bit ld,
                         input logic [31:0] ldval);
        bit done;
        bus.in_fmt        = fmt;
        bus.in_opcode     = op;
        bus.in_rd         = rd;
        bus.in_rs1        = rs1;
        bus.in_rs2        = rs2;
        bus.in_funct3     = f3;
        bus.in_funct7     = f7;
        bus.in_imm        = imm;
        bus.addr_load     = ld;
        bus.addr_load_val = ldval;
        bus.in_valid      = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 16 && !done; k++) begin
            cycle();
            done = last_acc;
        end
        if (!done) check("offer_timeout", 64'(0), 64'(1));
        bus.in_valid  = 1'b0;
        bus.addr_load = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] inst,
                               input logic [31:0] addr, input logic [1:0] code);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
        check({tag, "_inst"}, 64'(bus.out_inst), 64'(inst));
        check({tag, "_addr"}, 64'(bus.out_addr), 64'(addr));
        check({tag, "_code"}, 64'(bus.out_err_code), 64'(code));
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
    endtask

    function automatic logic [31:0] rand_imm();
        int sel;
        logic [31:0] edges [10];
        edges = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4096,
                  -32'sd4096, 32'h000F_FFFE, 32'hFFF0_0000, 32'h0010_0000};
        sel = int'($urandom_range(0, 5));
        case (sel)
            0: return $urandom;
            1: return 32'(int'($urandom_range(0, 10000)) - 5000);
            2: return edges[$urandom_range(0, 9)];
            3: return 32'(int'($urandom_range(0, 32'h0020_0000)) - 32'h0010_0000) & ~32'd1;
            4: return $urandom << 12;
            default: return 32'($urandom_range(0, 40));
        endcase
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_addr   = BASE;
        m_sticky = 1'b0;
        last_acc = 1'b0;
        rst_n    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_fmt = 3'd0;
        bus.in_opcode = 7'h0;
        bus.in_rd = 5'd0;
        bus.in_rs1 = 5'd0;
        bus.in_rs2 = 5'd0;
        bus.in_funct3 = 3'd0;
        bus.in_funct7 = 7'd0;
        bus.in_imm = 32'd0;
        bus.addr_load = 1'b0;
        bus.addr_load_val = 32'd0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        cycle();
        cycle();
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_inst", 64'(bus.out_inst), 64'(0));
        check("rst_out_addr", 64'(bus.out_addr), 64'(0));
        check("rst_out_err", 64'(bus.out_err), 64'(0));
        check("rst_sticky", 64'(bus.err_sticky), 64'(0));

        // add x3,x1,x2
        offer(3'd0, OpcOp, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0);
        expect_head("add", 32'h0020_81B3, 32'h0, 2'd0);
        drain();
        bus.addr_load = 1'b1;
        bus.addr_load_val = 32'h0;
        cycle();
        bus.addr_load = 1'b0;
        // addi x1,x0,-1 then jal x1,+8
        offer(3'd1, OpcOpImm, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0, 32'd0);
        expect_head("addi", 32'hFFF0_0093, 32'h0, 2'd0);
        offer(3'd6, OpcJal, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b0, 32'd0);
        expect_head("jal", 32'h0080_00EF, 32'h4, 2'd0);
        // beq x0,x0,-4 and error cases
        offer(3'd4, OpcBranch, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0, 32'd0);
        expect_head("beq", 32'hFE00_0EE3, 32'h8, 2'd0);
        check("sticky_clean", 64'(bus.err_sticky), 64'(0));
        offer(3'd4, OpcBranch, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'd0);
        expect_head("b_misal", Nop, 32'hC, 2'd2);
        offer(3'd1, OpcOpImm, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'd0);
        expect_head("i_range", Nop, 32'h10, 2'd1);
        offer(3'd7, OpcOp, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0);
        expect_head("fmt_ill", Nop, 32'h14, 2'd3);
        check("sticky_set", 64'(bus.err_sticky), 64'(1));
        drain();

        // Backpressure: two fill the FIFO, third waits, no bypass when full.
        bus.out_ready = 1'b0;
        offer(3'd0, OpcOp, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1, 32'h0);
        offer(3'd0, OpcOp, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0);
        bus.in_valid = 1'b1;
        bus.in_rd = 5'd3;
        #1;
        check("bp_full", 64'(bus.in_ready), 64'(0));
        cycle();
        bus.out_ready = 1'b1;
        offer(3'd0, OpcOp, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0);
        expect_head("bp_third", 32'h0000_01B3, 32'h8, 2'd0);
        drain();

        // Address load and wrap.
        offer(3'd5, OpcLui, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1, 32'h103);
        expect_head("ld_addr", 32'h1234_52B7, 32'h100, 2'd0);
        offer(3'd5, OpcAuipc, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, 1'b0, 32'h0);
        expect_head("ld_next", 32'h0000_1297, 32'h104, 2'd0);
        drain();
        bus.addr_load = 1'b1;
        bus.addr_load_val = 32'hFFFF_FFFC;
        cycle();
        bus.addr_load = 1'b0;
        offer(3'd2, OpcOpImm, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0, 32'd31, 1'b0, 32'h0);
        expect_head("wrap_top", 32'h01F1_1093, 32'hFFFF_FFFC, 2'd0);
        offer(3'd3, OpcStore, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFFFF_F800, 1'b0, 32'h0);
        expect_head("wrap_zero", 32'h8031_2023, 32'h0, 2'd0);
        drain();

        // Reset with two entries buffered.
        bus.out_ready = 1'b0;
        offer(3'd0, OpcOp, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0);
        offer(3'd7, OpcOp, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        #1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_sticky", 64'(bus.err_sticky), 64'(0));
        bus.out_ready = 1'b1;
        offer(3'd0, OpcOp, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'h0);
        expect_head("post_rst", 32'h0000_03B3, BASE, 2'd0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            bus.in_valid      = ($urandom_range(0, 3) != 0);
            bus.out_ready     = ($urandom_range(0, 2) != 0);
            bus.in_fmt        = 3'($urandom_range(0, 7));
            bus.in_opcode     = 7'($urandom);
            bus.in_rd         = 5'($urandom);
            bus.in_rs1        = 5'($urandom);
            bus.in_rs2        = 5'($urandom);
            bus.in_funct3     = 3'($urandom);
            bus.in_funct7     = 7'($urandom);
            bus.in_imm        = rand_imm();
            bus.addr_load     = ($urandom_range(0, 15) == 0);
            bus.addr_load_val = ($urandom_range(0, 1) != 0) ? $urandom
                                                            : 32'hFFFF_FFF0 | 32'($urandom);
            rst_n             = ($urandom_range(0, 199) != 0);
            cycle();
        end
        rst_n = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
